jk_counter_mod: RTL and testbench
=================================

// Module: jk_counter_mod
// PURPOSE
//  Parametrised synchronous up/down modulo-N counter built from per-bit JK flip-flops.
//  Generalises the fixed 3-bit JK up-counter:
//  - configurable width and modulus
//  - direction control, count enable, parallel load
//  - terminal-count flag
//  Used as a general event/timebase counter alongside other JK-based sequential blocks.
// PARAMETERS
//  WIDTH    4          counter width in bits (>=1)
//  MODULUS  2**WIDTH   count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
// PORTS
//  clk       in   1      rising-edge clock; the block's only clock
//  rst_n     in   1      reset, asynchronous assert, active-low
//  en        in   1      count enable
//  up        in   1      1 = count up, 0 = count down (sampled when en=1)
//  load      in   1      synchronous parallel load, priority over en
//  load_val  in   WIDTH  value to load; values >= MODULUS are clamped to MODULUS-1
//  q         out  WIDTH  counter state (flip-flop Q outputs)
//  tc        out  1      terminal count, combinational:
//                        en & ~load & (up ? q==MODULUS-1 : q==0)
//  q_gray    out  WIDTH  present only with JKCNT_GRAY_OUT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: rst_n=0 forces q=0 immediately, independent of clk.
//    While reset is held: tc=0 and q_gray=0.
//    Deassertion is synchronous to clk (external synchroniser). The first count occurs
//    on the first rising edge with rst_n=1.
//  - Storage: every bit is a JK FF, next state = (J & ~Q) | (~K & Q).
//    Updates only on posedge clk; latency 1 cycle from inputs to q.
//  - Priority per edge: load > en > hold.
//  - load=1: q <= min(load_val, MODULUS-1). Realised per bit as J=d, K=~d.
//    tc is 0 in this cycle.
//  - en=1, up=1, q<MODULUS-1: q <= q+1.
//    Bit i gets J=K=1 iff bits [i-1:0] are all 1.
//  - en=1, up=1, q==MODULUS-1: wrap, q <= 0. tc=1 during that cycle.
//  - en=1, up=0, q>0: q <= q-1.
//    Bit i gets J=K=1 iff bits [i-1:0] are all 0.
//  - en=1, up=0, q==0: wrap, q <= MODULUS-1. tc=1 during that cycle.
//  - en=0, load=0: J=K=0 on all bits; q holds.
//  - Direction change: takes effect on the very next edge. No dead cycle.
//  - Out-of-range q (only reachable through X or corruption, q >= MODULUS):
//    the next enabled edge forces q <= 0 regardless of up.
//  - Wrap arithmetic: counting wraps at MODULUS, never at 2**WIDTH unless they are equal.
//    No carry-out beyond tc.
//  - Reset asserted mid-count: q clears asynchronously, and any pending load or count is
//    discarded.
// CONFIGURATION
//  - JKCNT_GRAY_OUT_EN defined:
//    - adds output q_gray [WIDTH-1:0].
//    - q_gray is registered: q_gray <= next_q ^ (next_q >> 1).
//    - updated on the same edge as q; always equals Gray(q).
//    - reset value 0.
//  - JKCNT_GRAY_OUT_EN undefined:
//    - the q_gray port and its registers do not exist.
//    - all other behaviour is identical.
// STRUCTURE
//  - Package jk_cnt_pkg holds:
//    - typedef enum logic {CNT_DOWN=1'b0, CNT_UP=1'b1} cnt_dir_e
//    - function jk_next(j,k,q)
//    - localparam helpers for the MODULUS-1 terminal constant
//  - Sub-module jk_ff: single-bit JK flip-flop with clk, rst_n (async, active-low),
//    j, k, q. Instantiated WIDTH times by generate.
//  - Top level contains only the J/K decode, load clamp and tc logic.
// TESTING
//  - Reset: hold rst_n=0 mid-count at q=5, with no clk edge. Required:
//    q=0 immediately and tc=0; after release with en=1, up=1, q=1 on the first edge.
//  - Up wrap, WIDTH=4, MODULUS=10, en=1, up=1, 12 edges. Required:
//    q=1,2,..,9,0,1,2; tc=1 only while q==9.
//  - Down wrap, MODULUS=10, start q=2, up=0, 4 edges. Required:
//    q=1,0,9,8; tc=1 only while q==0.
//  - Load clamp, MODULUS=10: load=1, load_val=4'd13, en=1. Required:
//    q=9 after 1 edge and tc=0 in that cycle. Next edge with up=1, load=0: q=0.
//  - Hold and direction change: en=0 for 3 edges at q=6 -> q stays 6.
//    Then en=1 with up toggled each edge (1,0,1) -> q=7,6,7.
//  - With JKCNT_GRAY_OUT_EN, WIDTH=4, MODULUS=16, full up sweep. Required:
//    q_gray==q^(q>>1) every cycle; adjacent values differ in exactly 1 bit, including
//    the 15->0 wrap.

Source files
------------

// File: rtl/jk_cnt_pkg.sv
// Shared types and helpers for the JK-flip-flop based modulo-N counter.
package jk_cnt_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    localparam int unsigned JKCNT_MIN_MODULUS = 2;

    // Characteristic equation of a JK flip-flop.
    function automatic logic jk_next(input logic j, input logic k, input logic q);
        return (j & ~q) | (~k & q);
    endfunction

    // Terminal (highest legal) count for a given modulus.
    function automatic int unsigned term_count(input int unsigned modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/jk_ff.sv
// Single-bit JK flip-flop with asynchronous active-low reset.
module jk_ff
    import jk_cnt_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic state_q;
    logic state_d;

    assign state_d = jk_next(j, k, state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/jk_counter_mod.sv
// Up/down modulo-N counter built from per-bit JK flip-flops, with load and terminal count.
// Optional registered Gray-coded output when JKCNT_GRAY_OUT_EN is defined.
module jk_counter_mod
    import jk_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc
`ifdef JKCNT_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    localparam logic [WIDTH-1:0] TERM  = WIDTH'(term_count(MODULUS));
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    cnt_dir_e         dir;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic             out_of_range;

    assign dir = cnt_dir_e'(up);

    // Compare one bit wider so the checks stay meaningful when MODULUS == 2**WIDTH.
    assign out_of_range = ({1'b0, cnt_q} >= MOD_W);
    assign load_clamped = ({1'b0, load_val} >= MOD_W) ? TERM : load_val;

    always_comb begin
        logic ones;
        logic zeros;
        t_up  = '0;
        t_dn  = '0;
        ones  = 1'b1;
        zeros = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            t_up[i] = ones;
            t_dn[i] = zeros;
            ones    = ones & cnt_q[i];
            zeros   = zeros & ~cnt_q[i];
        end
    end

    always_comb begin
        j_d = '0;
        k_d = '0;
        if (load) begin
            j_d = load_clamped;
            k_d = ~load_clamped;
        end else if (en) begin
            if (out_of_range || (dir == CNT_UP && cnt_q == TERM)) begin
                k_d = '1;
            end else if (dir == CNT_DOWN && cnt_q == '0) begin
                j_d = TERM;
                k_d = ~TERM;
            end else if (dir == CNT_UP) begin
                j_d = t_up;
                k_d = t_up;
            end else begin
                j_d = t_dn;
                k_d = t_dn;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jk_ff u_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j_d[g]),
            .k     (k_d[g]),
            .q     (cnt_q[g])
        );
    end

    assign q  = cnt_q;
    assign tc = rst_n & en & ~load &
                ((dir == CNT_UP) ? (cnt_q == TERM) : (cnt_q == '0));

`ifdef JKCNT_GRAY_OUT_EN
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;

    always_comb begin
        next_q = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            next_q[i] = jk_next(j_d[i], k_d[i], cnt_q[i]);
        end
    end

    assign gray_d = next_q ^ (next_q >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign q_gray = gray_q;
`endif

endmodule

// File: tb/tb_jk_counter_mod.sv
// Scoreboard bench for jk_counter_mod (WIDTH=4, MODULUS=10) against an arithmetic model.
module tb_jk_counter_mod;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic         tc;
`ifdef JKCNT_GRAY_OUT_EN
    logic [W-1:0] q_gray;
`endif

    jk_counter_mod #(.WIDTH(W), .MODULUS(M)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc)
`ifdef JKCNT_GRAY_OUT_EN
        ,
        .q_gray   (q_gray)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int exp_q;
        bit exp_tc;
    } item_t;

    item_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    mq       = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one cycle of stimulus and push the model's prediction.
    task automatic step(input bit e, input bit u, input bit ld, input int lv);
        item_t it;
        int nxt;
        @(negedge clk);
        en = e; up = u; load = ld; load_val = W'(lv);
        it.exp_tc = e && !ld && (u ? (mq == M - 1) : (mq == 0));
        if (ld)      nxt = (lv > M - 1) ? M - 1 : lv;
        else if (e)  nxt = u ? (mq + 1) % M : (mq + M - 1) % M;
        else         nxt = mq;
        it.exp_q = nxt;
        sb.push_back(it);
        mq = nxt;
    endtask

    // Monitor: tc sampled mid-cycle, q sampled just after the edge.
    initial begin
        item_t it;
        bit    tc_s;
        forever begin
            @(negedge clk);
            #2 tc_s = tc;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                check("tc", int'(tc_s), int'(it.exp_tc));
                check("q", int'(q), it.exp_q);
`ifdef JKCNT_GRAY_OUT_EN
                check("q_gray", int'(q_gray), it.exp_q ^ (it.exp_q >> 1));
`endif
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0; en = 1'b1; up = 1'b0; load = 1'b0; load_val = '0;
        #1;
        check("reset_q", int'(q), 0);
        check("reset_tc", int'(tc), 0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-count, then first count after release.
        step(0, 0, 1, 5);
        step(0, 0, 0, 0);
        @(negedge clk);
        check("pre_reset_q", int'(q), 5);
        #3;
        en = 1'b1; up = 1'b0; rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_reset_q", int'(q), 0);
        check("async_reset_tc", int'(tc), 0);
        en = 1'b0;
        mq = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 0);

        // Up wrap over 12 edges.
        step(0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0);

        // Down wrap from 2.
        step(0, 0, 1, 2);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

        // Load clamp then wrap.
        step(1, 1, 1, 13);
        step(1, 1, 0, 0);

        // Hold, then direction toggling.
        step(0, 0, 1, 6);
        for (int i = 0; i < 3; i++) step(0, $urandom_range(0, 1), 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 15));
        end
        step(0, 0, 0, 0);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d items left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
